// File: rtl/hw_mon_pkg.sv
// Shared definitions for the hardware threshold monitor: channel FSM state
// encoding, counter widths and the per-channel violation rules.
package hw_mon_pkg;

  // Width of the per-channel debounce counter (debounce depth is 1..15).
  localparam int unsigned LP_CNT_W        = 4;
  // Width of the accepted-voltage-set counter.
  localparam int unsigned LP_SAMPLE_CNT_W = 16;

  // Per-channel supervision state.
  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_PEND  = 2'd1,
    ST_FAULT = 2'd2
  } chan_state_e;

  // Voltage window check: unsigned, both limits inclusive.
  function automatic logic volt_violates(input logic [31:0] value,
                                         input logic [31:0] thr_hi,
                                         input logic [31:0] thr_lo);
    return (value > thr_hi) || (value < thr_lo);
  endfunction

  // Temperature upper-limit check: signed degrees C, limit inclusive.
  function automatic logic temp_violates(input logic [7:0] value,
                                         input logic [7:0] thr_hi);
    return $signed(value) > $signed(thr_hi);
  endfunction

endpackage

// File: rtl/hw_thr_chan.sv
// One supervised channel: OK/PEND/FAULT state machine with a debounce
// counter. The FSM only advances on its group's strobe; a sticky FAULT is
// released by fault_clear once the latest sample was back in range.
module hw_thr_chan
  import hw_mon_pkg::*;
#(
  parameter int P_DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  input  logic viol_i,
  input  logic clear_i,
  output logic fault_o
);

  localparam logic [LP_CNT_W-1:0] LP_DEB = LP_CNT_W'(P_DEBOUNCE);
  localparam logic [LP_CNT_W-1:0] LP_ONE = LP_CNT_W'(1);
  localparam logic [LP_CNT_W-1:0] LP_ZERO = LP_CNT_W'(0);

  chan_state_e         state_q, state_d;
  logic [LP_CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic                last_viol_q, last_viol_d;
  logic                fault_q;

  // Next-state logic: debounce on strobes, violation has priority over clear.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc_s = cnt_q + LP_ONE;
    if (strobe_i) begin
      last_viol_d = viol_i;
    end else begin
      last_viol_d = last_viol_q;
    end
    case (state_q)
      ST_OK: begin
        if (strobe_i && viol_i) begin
          cnt_d = LP_ONE;
          if (LP_DEB <= LP_ONE) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_PEND;
          end
        end else begin
          cnt_d = LP_ZERO;
        end
      end
      ST_PEND: begin
        if (strobe_i) begin
          if (viol_i) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s >= LP_DEB) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_PEND;
            end
          end else begin
            state_d = ST_OK;
            cnt_d   = LP_ZERO;
          end
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_FAULT: begin
        // last_viol_d already reflects a same-cycle strobe, so a coincident
        // violating sample keeps the fault latched.
        if (clear_i && !last_viol_d) begin
          state_d = ST_OK;
          cnt_d   = LP_ZERO;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_OK;
        cnt_d   = LP_ZERO;
      end
    endcase
  end

  // State, debounce counter, last-sample flag and registered fault output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OK;
      cnt_q       <= LP_ZERO;
      last_viol_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_viol_q <= last_viol_d;
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign fault_o = fault_q;

endmodule

// File: rtl/hw_threshold_monitor.sv
// Voltage/temperature threshold monitor. Each channel is debounced by its own
// hw_thr_chan instance; faults are sticky until fault_clear.
// Optional feature macro: HW_THRESHOLD_WATCHDOG_EN adds a stale-data watchdog
// on voltage_good that drives stale_fault and feeds fault_any.
module hw_threshold_monitor
  import hw_mon_pkg::*;
#(
  parameter int P_NO_CH_VOLT  = 9,
  parameter int P_NO_CH_TEMP  = 5,
  parameter int P_DEBOUNCE    = 3,
  parameter int P_TIMEOUT_CYC = 1000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              voltage_good,
  input  logic                              temperature_good,
  input  logic [P_NO_CH_VOLT-1:0][31:0]     voltage_collection,
  input  logic [P_NO_CH_TEMP-1:0][7:0]      temperature_collection,
  input  logic [P_NO_CH_VOLT-1:0][31:0]     volt_thr_hi,
  input  logic [P_NO_CH_VOLT-1:0][31:0]     volt_thr_lo,
  input  logic [P_NO_CH_TEMP-1:0][7:0]      temp_thr_hi,
  input  logic                              fault_clear,
  output logic [P_NO_CH_VOLT-1:0]           volt_fault,
  output logic [P_NO_CH_TEMP-1:0]           temp_fault,
  output logic                              fault_any,
  output logic                              stale_fault,
  output logic [LP_SAMPLE_CNT_W-1:0]        sample_count
);

  // Parameter range guard: an out-of-range debounce depth or timeout
  // elaborates this empty marker block, visible in the design hierarchy.
  if ((P_DEBOUNCE < 1) || (P_DEBOUNCE > 15) || (P_TIMEOUT_CYC < 1)) begin : g_param_out_of_range
  end

  logic [P_NO_CH_VOLT-1:0]      volt_viol_s;
  logic [P_NO_CH_TEMP-1:0]      temp_viol_s;
  logic [P_NO_CH_VOLT-1:0]      volt_fault_s;
  logic [P_NO_CH_TEMP-1:0]      temp_fault_s;
  logic                         stale_s;
  logic                         fault_any_q, fault_any_d;
  logic [LP_SAMPLE_CNT_W-1:0]   sample_count_q, sample_count_d;

  // Per-channel violation flags from the current inputs; only consumed on strobes.
  always_comb begin
    volt_viol_s = {P_NO_CH_VOLT{1'b0}};
    temp_viol_s = {P_NO_CH_TEMP{1'b0}};
    for (int i = 0; i < P_NO_CH_VOLT; i++) begin
      volt_viol_s[i] = volt_violates(voltage_collection[i], volt_thr_hi[i], volt_thr_lo[i]);
    end
    for (int j = 0; j < P_NO_CH_TEMP; j++) begin
      temp_viol_s[j] = temp_violates(temperature_collection[j], temp_thr_hi[j]);
    end
  end

  for (genvar gv = 0; gv < P_NO_CH_VOLT; gv++) begin : g_volt_chan
    hw_thr_chan #(.P_DEBOUNCE(P_DEBOUNCE)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .strobe_i (voltage_good),
      .viol_i   (volt_viol_s[gv]),
      .clear_i  (fault_clear),
      .fault_o  (volt_fault_s[gv])
    );
  end

  for (genvar gt = 0; gt < P_NO_CH_TEMP; gt++) begin : g_temp_chan
    hw_thr_chan #(.P_DEBOUNCE(P_DEBOUNCE)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .strobe_i (temperature_good),
      .viol_i   (temp_viol_s[gt]),
      .clear_i  (fault_clear),
      .fault_o  (temp_fault_s[gt])
    );
  end

`ifdef HW_THRESHOLD_WATCHDOG_EN
  localparam int unsigned       LP_WD_W     = $clog2(P_TIMEOUT_CYC + 1);
  localparam logic [LP_WD_W-1:0] LP_WD_LIMIT = LP_WD_W'(P_TIMEOUT_CYC);
  localparam logic [LP_WD_W-1:0] LP_WD_ONE   = LP_WD_W'(1);
  localparam logic [LP_WD_W-1:0] LP_WD_ZERO  = LP_WD_W'(0);

  logic [LP_WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic               stale_q, stale_d;
  logic               vg_seen_q, vg_seen_d;

  // Watchdog next state: count idle cycles, latch stale, release on clear after fresh data.
  always_comb begin
    if (voltage_good) begin
      wd_cnt_d = LP_WD_ZERO;
    end else if (wd_cnt_q != LP_WD_LIMIT) begin
      wd_cnt_d = wd_cnt_q + LP_WD_ONE;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end

    if (wd_cnt_q == LP_WD_LIMIT) begin
      stale_d = 1'b1;
    end else if (stale_q && fault_clear && (vg_seen_q || voltage_good)) begin
      stale_d = 1'b0;
    end else begin
      stale_d = stale_q;
    end

    // Remember that fresh voltage data arrived while stale was latched.
    if (!stale_q) begin
      vg_seen_d = 1'b0;
    end else if (voltage_good) begin
      vg_seen_d = 1'b1;
    end else begin
      vg_seen_d = vg_seen_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q  <= LP_WD_ZERO;
      stale_q   <= 1'b0;
      vg_seen_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      stale_q   <= stale_d;
      vg_seen_q <= vg_seen_d;
    end
  end

  assign stale_s = stale_q;
`else
  assign stale_s = 1'b0;
`endif

  // Summary fault and wrapping sample counter next state.
  always_comb begin
    fault_any_d = (|volt_fault_s) || (|temp_fault_s) || stale_s;
    if (voltage_good) begin
      sample_count_d = sample_count_q + LP_SAMPLE_CNT_W'(1);
    end else begin
      sample_count_d = sample_count_q;
    end
  end

  // Summary fault register (one cycle behind the channel faults) and sample counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_any_q    <= 1'b0;
      sample_count_q <= LP_SAMPLE_CNT_W'(0);
    end else begin
      fault_any_q    <= fault_any_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign volt_fault   = volt_fault_s;
  assign temp_fault   = temp_fault_s;
  assign fault_any    = fault_any_q;
  assign stale_fault  = stale_s;
  assign sample_count = sample_count_q;

endmodule
